tx_port_arbiter: RTL and testbench
==================================

# tx_port_arbiter

Round-robin arbiter and sequencer that shares one `dclk_tx` serial transmitter among `N_REQ` local requesters (router input buffers or local injection port) on one output direction. It grants one requester at a time and latches its item. It pulses the transmitter's `req`, then holds off further grants until the transmitter reports the serial transfer complete via `tx_busy`. It sits in the write-clock domain, directly upstream of `dclk_tx`.

## Interface
- `N_REQ`, 4: number of requesters (1..8).
- `GRANT_BITS`, 2: width of `grant_id`; must satisfy 2^GRANT_BITS >= N_REQ.
- `TIMEOUT`, 8: WAIT_START cycles without `tx_busy` before `tx_req` is re-issued (>= 2).
- `ID`, 0: port identifier, informational.
- `DIR`, "east": direction string, informational.
- W = `PAYLOAD_SIZE+`ADDR_BITS throughout.

Ports:
- `clk`  in  1  single clock; the `dclk_tx` write clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  N_REQ  bit i high: requester i holds an item on its `in_data` slice.
- `in_data`  in  N_REQ*W  item i occupies bits [i*W +: W].
- `in_ack`  out  N_REQ  one-cycle pulse: item i captured; requester presents its next item or drops `in_valid`.
- `tx_req`  out  1  one-cycle request pulse to `dclk_tx` `req`.
- `tx_data`  out  W  to `dclk_tx` `parallel_in`; stable from the `tx_req` cycle until the transfer completes.
- `tx_busy`  in  1  from `dclk_tx`; high while serialising.
- `channel_busy`  in  1  downstream `dclk_rx` full/busy flag.
- `grant_id`  out  GRANT_BITS  index of the current or last granted requester.
- `arb_busy`  out  1  high in any state other than IDLE.
- `retry`  out  1  one-cycle pulse when a timeout re-issues `tx_req`.
- `tx_count`  out  16  completed transfers; wraps 0xFFFF to 0.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE. All outputs are registered.
- **IDLE**
  - Grant condition: any `in_valid` high, `tx_busy`=0 and `channel_busy`=0.
  - Winner: first index with `in_valid` set, searched from `grant_id`+1 mod N_REQ upward, wrapping round. The requester just served therefore has the lowest priority.
  - On grant: latch its slice into `tx_data`, load `grant_id`, pulse `in_ack[winner]`, go to ISSUE.
- **ISSUE**: `tx_req`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_START.
- **WAIT_START**
  - `tx_busy`=1: go to WAIT_DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1, pulse `retry` and return to ISSUE.
  - On a retry, `tx_data` and `grant_id` are unchanged and no `in_ack` is issued.
- **WAIT_DONE**: `tx_busy`=0 returns to IDLE and increments `tx_count`.
- `in_valid` and `in_data` are ignored outside IDLE. Changes to them after a grant do not affect the latched item.
- N_REQ=1: the grant search degenerates to requester 0.
- `in_valid` bits at index >= N_REQ do not exist. `grant_id` never exceeds N_REQ-1.

## Timing
- Reset (synchronous, one edge) sets:
  - state=IDLE, `in_ack`=0, `tx_req`=0, `retry`=0, `arb_busy`=0;
  - `tx_data`=0, `tx_count`=0;
  - `grant_id`=N_REQ-1, so requester 0 has first priority.
- Grant latency: qualifying IDLE in cycle T gives `in_ack` and ISSUE state in cycle T+1, with `tx_req`=1 in T+1. `in_ack` and `tx_req` are coincident.
- `arb_busy` goes high in T+1 and stays high until the cycle after `tx_busy` falls.
- Earliest next grant: the first IDLE cycle, one cycle after the WAIT_DONE exit, provided `tx_busy`=0 and `channel_busy`=0.
- `channel_busy` or `tx_busy` high in IDLE: no grant and no ack.
- `channel_busy` is not sampled after the grant; `dclk_tx` handles flow control for the issued item.
- `tx_busy` already high in WAIT_START's first cycle: go to WAIT_DONE immediately.
- `tx_busy` pulse shorter than one cycle: not supported.
- Reset mid-transfer: the arbiter returns to IDLE; the transmitter finishes on its own. The IDLE `tx_busy`=0 gate keeps the arbiter from issuing until the transmitter finishes.
- Reset and a grant condition in the same cycle: reset wins.
- `tx_count` increments in the WAIT_DONE to IDLE cycle only, never on a retry.

## Test plan
1. **Reset priority**: reset 2 cycles, then `in_valid`=4'b1111 with distinct items 1..4 -> requesters served in order 0,1,2,3. Each `in_ack` is coincident with `tx_req`; `tx_data` equals that requester's item; `tx_count` ends at 4.
2. **Round-robin skip**: `grant_id`=1, `in_valid`=4'b1001 -> grant 3, then 0. A requester held continuously high alongside others never gets two consecutive grants.
3. **Backpressure**: `channel_busy`=1 for 20 cycles with `in_valid`=4'b0010 -> no `in_ack` and no `tx_req`. Grant occurs the cycle after `channel_busy` falls.
4. **Timeout retry**: TIMEOUT=8 and `tx_busy` held low -> `retry` pulses every 8 cycles with `tx_req` re-issued. `tx_data`=8'hFF is unchanged, a single `in_ack` is seen, and `tx_count` does not move.
5. **Reset mid-transfer**: assert reset during WAIT_DONE with `tx_busy`=1 -> next cycle all outputs are at reset values. No grant occurs until `tx_busy` falls.
6. **Counter wrap**: preload 0xFFFF via 65535 transfers, or force the counter in the bench -> one more completion gives `tx_count`=0.

Source files
------------

// File: rtl/tx_port_arbiter.sv
// tx_port_arbiter: round-robin arbiter that shares one dclk_tx serial
// transmitter among N_REQ local requesters on one output direction.
// It grants one requester, latches its item, pulses tx_req, then waits for
// the transmitter's tx_busy high/low cycle before it grants again.
//
// Requester handshake: a requester holds in_valid[i] high with a stable item
// on its in_data slice until it sees a one-cycle in_ack[i]. The item is
// captured in that cycle. In the next cycle the requester either presents
// its next item or drops in_valid[i]. in_valid/in_data are only sampled in
// IDLE.
`timescale 1ns/1ps

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 6
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 2
`endif

module tx_port_arbiter #(
    parameter int N_REQ      = 4,
    parameter int GRANT_BITS = 2,
    parameter int TIMEOUT    = 8,
    parameter int ID         = 0,
    parameter     DIR        = "east",
    localparam int W         = `PAYLOAD_SIZE + `ADDR_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ*W-1:0]      in_data,
    output logic [N_REQ-1:0]        in_ack,
    output logic                    tx_req,
    output logic [W-1:0]            tx_data,
    input  logic                    tx_busy,
    input  logic                    channel_busy,
    output logic [GRANT_BITS-1:0]   grant_id,
    output logic                    arb_busy,
    output logic                    retry,
    output logic [15:0]             tx_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Counter value at which the next increment would reach TIMEOUT-1.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

    // Reject parameter sets the grant search and timeout cannot support.
    if (N_REQ < 1 || N_REQ > 8 || (2 ** GRANT_BITS) < N_REQ || TIMEOUT < 2) begin : g_param_check
        $error("tx_port_arbiter %0d (%s): invalid parameters", ID, DIR);
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    pick_found;
    logic [GRANT_BITS-1:0]   pick_idx;
    logic [N_REQ-1:0]        ack_d;
    logic                    req_d;
    logic                    retry_d;
    logic [W-1:0]            data_d;
    logic [GRANT_BITS-1:0]   gid_d;
    logic [15:0]             cnt_d;

    // Round-robin search: first valid requester after the last grant, wrapping.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(grant_id) + k) % N_REQ;
            if (!pick_found && in_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = GRANT_BITS'(cand);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        ack_d   = '0;
        req_d   = 1'b0;
        retry_d = 1'b0;
        data_d  = tx_data;
        gid_d   = grant_id;
        cnt_d   = tx_count;
        case (state_q)
            IDLE: begin
                // tx_busy gate also covers a transfer left running across reset.
                if (pick_found && !tx_busy && !channel_busy) begin
                    state_d         = ISSUE;
                    data_d          = in_data[pick_idx*W +: W];
                    gid_d           = pick_idx;
                    ack_d[pick_idx] = 1'b1;
                    req_d           = 1'b1;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    // Re-issue the same item; no new ack, data and grant held.
                    state_d = ISSUE;
                    req_d   = 1'b1;
                    retry_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    cnt_d   = tx_count + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            in_ack   <= '0;
            tx_req   <= 1'b0;
            retry    <= 1'b0;
            arb_busy <= 1'b0;
            tx_data  <= '0;
            grant_id <= GRANT_BITS'(N_REQ - 1);
            tx_count <= 16'd0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            in_ack   <= ack_d;
            tx_req   <= req_d;
            retry    <= retry_d;
            arb_busy <= (state_d != IDLE);
            tx_data  <= data_d;
            grant_id <= gid_d;
            tx_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Bench for tx_port_arbiter: requester sources, a simple dclk_tx busy model,
// and a scoreboard of expected {grant_id, tx_data} pairs checked on each ack.
`timescale 1ns/1ps

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 6
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 2
`endif

module tb_tx_port_arbiter;

    localparam int N_REQ      = 4;
    localparam int GRANT_BITS = 2;
    localparam int TIMEOUT    = 8;
    localparam int W          = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int EW         = GRANT_BITS + W;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]      in_valid;
    logic [N_REQ*W-1:0]    in_data;
    logic [N_REQ-1:0]      in_ack;
    logic                  tx_req;
    logic [W-1:0]          tx_data;
    logic                  tx_busy;
    logic                  channel_busy;
    logic [GRANT_BITS-1:0] grant_id;
    logic                  arb_busy;
    logic                  retry;
    logic [15:0]           tx_count;

    // transmitter model controls
    logic xmit_auto;
    logic busy_manual;
    int   busy_left;
    assign tx_busy = xmit_auto ? (busy_left != 0) : busy_manual;

    // requester sources
    logic [W-1:0] src_data [N_REQ][2];
    int           src_len  [N_REQ];
    int           src_pos  [N_REQ];

    // scoreboard
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  last_data;
    int            ack_seen;
    int            n_checks;
    int            n_fail;

    tx_port_arbiter #(
        .N_REQ(N_REQ), .GRANT_BITS(GRANT_BITS), .TIMEOUT(TIMEOUT), .ID(0), .DIR("east")
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
        .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy), .channel_busy(channel_busy),
        .grant_id(grant_id), .arb_busy(arb_busy), .retry(retry), .tx_count(tx_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input logic [GRANT_BITS-1:0] id, input logic [W-1:0] d);
        exp_q.push_back({id, d});
    endtask

    task automatic present(input int i, input int n, input logic [W-1:0] d0, input logic [W-1:0] d1);
        src_data[i][0] = d0;
        src_data[i][1] = d1;
        src_len[i]     = n;
        src_pos[i]     = 0;
        in_data[i*W +: W] = d0;
        in_valid[i]       = 1'b1;
    endtask

    // One cycle: sample at negedge, run transmitter model, scoreboard, sources.
    task automatic tick();
        logic [EW-1:0] e;
        @(negedge clk);
        if (xmit_auto && tx_req) busy_left = 3;
        else if (busy_left > 0) busy_left--;
        if (in_ack != '0) begin
            ack_seen++;
            check_eq("ack_with_tx_req", tx_req, 1);
            check_eq("ack_arb_busy", arb_busy, 1);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_grant", in_ack, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("grant_id", grant_id, e[EW-1:W]);
                check_eq("tx_data", tx_data, e[W-1:0]);
                check_eq("ack_onehot", in_ack, 32'(1) << e[EW-1:W]);
            end
            last_data = tx_data;
        end else if (tx_req) begin
            check_eq("retry_data_held", tx_data, last_data);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (in_ack[i]) begin
                src_pos[i]++;
                if (src_pos[i] < src_len[i]) in_data[i*W +: W] = src_data[i][src_pos[i]];
                else in_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || arb_busy || tx_busy) && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        check_eq({tag, "_idle"}, arb_busy, 0);
    endtask

    task automatic wait_ack(input string tag, input int i, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!in_ack[i] && n < budget);
        check_eq(tag, in_ack[i], 1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in_ack"}, in_ack, 0);
        check_eq({tag, "_tx_req"}, tx_req, 0);
        check_eq({tag, "_retry"}, retry, 0);
        check_eq({tag, "_arb_busy"}, arb_busy, 0);
        check_eq({tag, "_tx_data"}, tx_data, 0);
        check_eq({tag, "_tx_count"}, tx_count, 0);
        check_eq({tag, "_grant_id"}, grant_id, N_REQ - 1);
    endtask

    initial begin
        int saw, n, reqs, last_t, ack0;
        logic [15:0] cnt0;

        reset = 1'b1; in_valid = '0; in_data = '0; channel_busy = 1'b0;
        xmit_auto = 1'b1; busy_manual = 1'b0; busy_left = 0;
        last_data = '0; ack_seen = 0; n_checks = 0; n_fail = 0;
        for (int i = 0; i < N_REQ; i++) begin src_len[i] = 0; src_pos[i] = 0; end

        // Reset state and reset priority
        tick(); tick();
        check_reset_state("reset");
        reset = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            present(i, 1, W'(i + 1), '0);
            expect_grant(GRANT_BITS'(i), W'(i + 1));
        end
        drain("priority", 100);
        check_eq("priority_tx_count", tx_count, 4);

        // Round-robin skip: move grant_id to 1, then requesters 0 and 3 each with two items
        present(1, 1, 8'h11, '0);
        expect_grant(1, 8'h11);
        wait_ack("rr_setup_ack", 1, 20);
        present(0, 2, 8'hA0, 8'hA1);
        present(3, 2, 8'hD0, 8'hD1);
        expect_grant(3, 8'hD0);
        expect_grant(0, 8'hA0);
        expect_grant(3, 8'hD1);
        expect_grant(0, 8'hA1);
        drain("rr", 100);
        check_eq("rr_tx_count", tx_count, 9);

        // Backpressure: channel_busy blocks the grant
        channel_busy = 1'b1;
        present(1, 1, 8'h55, '0);
        saw = 0;
        repeat (20) begin
            tick();
            if (in_ack != '0 || tx_req) saw++;
        end
        check_eq("bp_no_grant", saw, 0);
        expect_grant(1, 8'h55);
        channel_busy = 1'b0;
        tick();
        check_eq("bp_release_ack", in_ack, 4'b0010);
        drain("bp", 50);

        // Timeout retry with tx_busy held low
        xmit_auto = 1'b0; busy_manual = 1'b0;
        cnt0 = tx_count; ack0 = ack_seen;
        present(2, 1, 8'hFF, '0);
        expect_grant(2, 8'hFF);
        n = 0; reqs = 0; last_t = 0;
        while (reqs < 4 && n < 80) begin
            tick();
            n++;
            if (tx_req) begin
                if (reqs > 0) begin
                    check_eq("retry_pulse", retry, 1);
                    check_eq("retry_gap", n - last_t, TIMEOUT);
                end else begin
                    check_eq("first_req_no_retry", retry, 0);
                end
                last_t = n;
                reqs++;
            end else if (retry) begin
                check_eq("retry_without_req", retry, 0);
            end
        end
        check_eq("retry_req_count", reqs, 4);
        check_eq("retry_single_ack", ack_seen - ack0, 1);
        check_eq("retry_count_frozen", tx_count, cnt0);
        busy_manual = 1'b1;
        tick(); tick();
        busy_manual = 1'b0;
        drain("retry", 30);
        check_eq("retry_done_count", tx_count, 16'(cnt0 + 16'd1));

        // Reset mid-transfer while the transmitter is still busy
        present(3, 1, 8'h77, '0);
        expect_grant(3, 8'h77);
        wait_ack("mid_ack", 3, 20);
        busy_manual = 1'b1;
        tick(); tick();
        check_eq("mid_in_wait_done", arb_busy, 1);
        reset = 1'b1;
        tick();
        check_reset_state("midreset");
        reset = 1'b0;
        present(0, 1, 8'h99, '0);
        saw = 0;
        repeat (5) begin
            tick();
            if (in_ack != '0 || tx_req) saw++;
        end
        check_eq("midreset_no_grant", saw, 0);
        expect_grant(0, 8'h99);
        busy_manual = 1'b0;
        xmit_auto = 1'b1;
        tick();
        check_eq("midreset_grant", in_ack, 4'b0001);
        drain("midreset", 30);
        check_eq("midreset_count", tx_count, 1);

        // Counter wrap from 0xFFFF
        force dut.tx_count = 16'hFFFF;
        #1;
        release dut.tx_count;
        check_eq("wrap_preload", tx_count, 16'hFFFF);
        present(1, 1, 8'h42, '0);
        expect_grant(1, 8'h42);
        drain("wrap", 30);
        check_eq("wrap_count", tx_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
